ex_stage: RTL

//  Execute stage of the 5-stage PipelineCPU. Consumes the ID/EX register outputs and computes the ALU result.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/ex_stage_if.sv | 22 ++
 rtl/ex_iter_mul.sv | 85 ++++++++
 rtl/ex_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the PipelineCPU execute stage: ALU op codes, RegDst/MemtoReg
// encodings and the EX multiplier FSM state.
package cpu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_MUL  = 4'd12
   } alu_op_t;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;
   localparam logic [4:0] RA_REG    = 5'd31;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [1:0] {
      EX_IDLE = 2'd0,
      EX_BUSY = 2'd1,
      EX_DONE = 2'd2
   } ex_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// EX/MEM pipeline register bundle: ex_stage drives it (master), the MEM stage
// consumes it (slave).
interface ex_stage_if;
   logic        mem_RegWr;
   logic        mem_MemRead;
   logic        mem_MemWrite;
   logic [1:0]  mem_MemtoReg;
   logic [4:0]  mem_WriteReg;
   logic [31:0] mem_ALUOut;
   logic [31:0] mem_WriteData;
   logic [31:0] mem_PC_Plus_4;

   modport master (
      output mem_RegWr, mem_MemRead, mem_MemWrite, mem_MemtoReg,
             mem_WriteReg, mem_ALUOut, mem_WriteData, mem_PC_Plus_4
   );

   modport slave (
      input  mem_RegWr, mem_MemRead, mem_MemWrite, mem_MemtoReg,
             mem_WriteReg, mem_ALUOut, mem_WriteData, mem_PC_Plus_4
   );
endinterface

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier (low 32 bits), MUL_BPC multiplier bits per cycle,
// with an IDLE -> BUSY -> DONE handshake; product is valid while done is high.
module ex_iter_mul
   import cpu_pkg::*;
#(
   parameter int MUL_BPC = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   localparam int MUL_CYCLES = 32 / MUL_BPC;
   localparam int CNT_W      = $clog2(MUL_CYCLES);

   ex_state_t        state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      mcand, mplier, acc;
   logic             last_step;

   function automatic logic [31:0] shift_add(input logic [31:0] acc_in,
                                             input logic [31:0] mc,
                                             input logic [MUL_BPC-1:0] mp);
      logic [31:0] sum;
      sum = acc_in;
      for (int i = 0; i < MUL_BPC; i++) begin
         if (mp[i]) sum = sum + (mc << i);
      end
      return sum;
   endfunction

   // The start cycle already retires step 0, so cnt holds the index of the step
   // BUSY retires next; DONE follows the step with index MUL_CYCLES-1.
   assign last_step = (cnt == CNT_W'(MUL_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EX_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         EX_IDLE: if (start) state_next = EX_BUSY;
         EX_BUSY: begin
            busy = 1'b1;
            if (last_step) state_next = EX_DONE;
         end
         EX_DONE: begin
            done       = 1'b1;
            state_next = EX_IDLE;
         end
         default: state_next = EX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (state == EX_IDLE && start) begin
         acc    <= shift_add(32'd0, a, b[MUL_BPC-1:0]);
         mcand  <= a << MUL_BPC;
         mplier <= b >> MUL_BPC;
         cnt    <= CNT_W'(1);
      end else if (state == EX_BUSY) begin
         acc    <= shift_add(acc, mcand, mplier[MUL_BPC-1:0]);
         mcand  <= mcand << MUL_BPC;
         mplier <= mplier >> MUL_BPC;
         cnt    <= cnt + 1'b1;
      end
   end

   assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolve/flush, iterative MUL with front-end stall, EX/MEM register.
// Optional macro EX_FORWARD_EN adds EX/MEM and WB operand forwarding.
module ex_stage
   import cpu_pkg::*;
#(
   parameter int MUL_BPC = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_RegWr,
   input  logic        ex_Branch,
   input  logic        ex_BranchClip,
   input  logic        ex_MemRead,
   input  logic        ex_MemWrite,
   input  logic        ex_ALUSrcA,
   input  logic        ex_ALUSrcB,
   input  logic [1:0]  ex_MemtoReg,
   input  logic [3:0]  ex_ALUOp,
   input  logic [1:0]  ex_RegDst,
   input  logic [31:0] ex_ReadData1,
   input  logic [31:0] ex_ReadData2,
   input  logic [31:0] ex_imm_ext,
   input  logic [31:0] ex_PC_Plus_4,
   input  logic [4:0]  ex_Shamt,
   input  logic [4:0]  ex_rt,
   input  logic [4:0]  ex_rd,
`ifdef EX_FORWARD_EN
   input  logic [4:0]  ex_rs,
   input  logic        wb_RegWr,
   input  logic [4:0]  wb_WriteReg,
   input  logic [31:0] wb_WriteData,
`endif
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] br_target_o,
   ex_stage_if.master  mem
);

   logic [31:0] rd1, rd2, op_a, op_b, alu_res, product;
   logic        is_mul, mul_busy, mul_done, taken;
   logic [4:0]  write_reg;

   function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return {31'd0, ($signed(a) < $signed(b))};
         ALU_SLTU: return {31'd0, (a < b)};
         ALU_SLL:  return b << a[4:0];
         ALU_SRL:  return b >> a[4:0];
         ALU_SRA:  return 32'($signed(b) >>> a[4:0]);
         ALU_LUI:  return b << 16;
         default:  return a + b;   // ADD, the MUL slot, and the spare codes 13-15
      endcase
   endfunction

`ifdef EX_FORWARD_EN
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] raw,
                                       input logic mem_ok, input logic [4:0] mem_reg,
                                       input logic [31:0] mem_data, input logic wb_ok,
                                       input logic [4:0] wb_reg, input logic [31:0] wb_data);
      if (r == 5'd0)                return raw;
      if (mem_ok && mem_reg == r)   return mem_data;
      if (wb_ok && wb_reg == r)     return wb_data;
      return raw;
   endfunction

   logic mem_fwd_ok;
   // Loads are still in flight in MEM, so only ALU results are forwarded from EX/MEM.
   assign mem_fwd_ok = mem.mem_RegWr && (mem.mem_MemtoReg == WB_ALU);
   assign rd1 = fwd(ex_rs, ex_ReadData1, mem_fwd_ok, mem.mem_WriteReg, mem.mem_ALUOut,
                    wb_RegWr, wb_WriteReg, wb_WriteData);
   assign rd2 = fwd(ex_rt, ex_ReadData2, mem_fwd_ok, mem.mem_WriteReg, mem.mem_ALUOut,
                    wb_RegWr, wb_WriteReg, wb_WriteData);
`else
   assign rd1 = ex_ReadData1;
   assign rd2 = ex_ReadData2;
`endif

   assign op_a    = ex_ALUSrcA ? {27'd0, ex_Shamt} : rd1;
   assign op_b    = ex_ALUSrcB ? ex_imm_ext : rd2;
   assign alu_res = alu(alu_op_t'(ex_ALUOp), op_a, op_b);
   assign is_mul  = (alu_op_t'(ex_ALUOp) == ALU_MUL);

   ex_iter_mul #(.MUL_BPC(MUL_BPC)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (is_mul),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   // The MUL stays parked in ID/EX until its product is ready; stall beats flush.
   assign stall_o     = ~reset & (mul_busy | (is_mul & ~mul_done));
   assign taken       = ex_Branch & (ex_BranchClip ? (rd1 != rd2) : (rd1 == rd2));
   assign flush_o     = taken & ~stall_o;
   assign br_target_o = ex_PC_Plus_4 + (ex_imm_ext << 2);

   always_comb begin
      case (ex_RegDst)
         REGDST_RD: write_reg = ex_rd;
         REGDST_RA: write_reg = RA_REG;
         default:   write_reg = ex_rt;
      endcase
   end

   // EX/MEM register boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset || stall_o) begin
         mem.mem_RegWr     <= 1'b0;
         mem.mem_MemRead   <= 1'b0;
         mem.mem_MemWrite  <= 1'b0;
         mem.mem_MemtoReg  <= '0;
         mem.mem_WriteReg  <= '0;
         mem.mem_ALUOut    <= '0;
         mem.mem_WriteData <= '0;
         mem.mem_PC_Plus_4 <= '0;
      end else begin
         mem.mem_RegWr     <= ex_RegWr & ~ex_Branch;
         mem.mem_MemRead   <= ex_MemRead;
         mem.mem_MemWrite  <= ex_MemWrite;
         mem.mem_MemtoReg  <= ex_MemtoReg;
         mem.mem_WriteReg  <= write_reg;
         mem.mem_ALUOut    <= is_mul ? product : alu_res;
         mem.mem_WriteData <= rd2;
         mem.mem_PC_Plus_4 <= ex_PC_Plus_4;
      end
   end

endmodule
